// File: rtl/wb_host_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_host_master
// Brief    : Wishbone B-4 classic initiator. Converts a valid/ready request
//            port into single non-pipelined Wishbone read/write cycles and
//            returns the result on a valid/ready response port. One
//            transaction is outstanding at a time.
// Options  : define WB_HM_TIMEOUT_EN to abort a bus cycle after TIMEOUT
//            cycles without ack/err (reported as an error response).
// Revision : 1.0 - initial release
// ============================================================================
module wb_host_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // request port
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  // response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  // Wishbone initiator
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        cyc_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_dat_q;
  logic        tmo_hit;

`ifdef WB_HM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] tmo_cnt_q;
  logic [15:0] tmo_cnt_d;

  // Count BUS cycles that pass without ack/err; held at zero outside BUS so
  // every new bus cycle starts counting from zero.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != ST_BUS) begin
      tmo_cnt_d = '0;
    end else if (!wb_ack_i && !wb_err_i) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Last silent cycle: abort on this edge unless ack/err arrives with it.
  assign tmo_hit = (state_q == ST_BUS) && (tmo_cnt_q == TMO_LAST);
`else
  // Without the timeout option the bus waits indefinitely for the target.
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign tmo_hit        = 1'b0;
`endif

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            adr_q   <= req_adr_i;
            dat_q   <= req_dat_i;
            sel_q   <= req_sel_i;
            cyc_q   <= 1'b1;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          // err outranks ack, and a real termination outranks the timeout
          if (wb_err_i) begin
            cyc_q       <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (wb_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= we_q ? 32'h0 : wb_dat_i;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (tmo_hit) begin
            cyc_q       <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_host_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_host_master
// Brief    : Scoreboard bench for wb_host_master. A driver issues requests
//            and pushes model responses; a Wishbone target model replays a
//            per-transaction script; a monitor pops and compares responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_host_master;

  localparam int unsigned TIMEOUT = 8;

  typedef struct {
    int          delay;
    bit          silent;
    bit          ack;
    bit          err;
    logic [31:0] rdata;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
  } txn_t;

  typedef struct {
    logic [31:0] dat;
    bit          err;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready_o;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat;
  logic        wb_ack;
  logic        wb_err;

  int   checks;
  int   failures;
  txn_t slv_q[$];
  rsp_t exp_q[$];
  bit   bp_hold;
  bit   bp_random;
  bit   spur_en;

  wb_host_master #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we),
    .req_adr_i   (req_adr),
    .req_dat_i   (req_dat),
    .req_sel_i   (req_sel),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_i    (wb_dat),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fail(input string name, input string detail);
    failures++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  // Reference behaviour: errors and timeouts return 0 with err; writes
  // return 0; reads return what the target supplied.
  function automatic rsp_t model_rsp(input txn_t t);
    rsp_t r;
    if (t.err || t.silent) begin
      r.dat = 32'h0;
      r.err = 1'b1;
    end else begin
      r.err = 1'b0;
      r.dat = t.we ? 32'h0 : t.rdata;
    end
    return r;
  endfunction

  function automatic txn_t mk(input bit we, input logic [31:0] adr,
                              input logic [31:0] wdat, input logic [3:0] sel,
                              input int delay, input bit ack, input bit err,
                              input bit silent, input logic [31:0] rdata);
    txn_t t;
    t.we = we; t.adr = adr; t.wdat = wdat; t.sel = sel;
    t.delay = delay; t.ack = ack; t.err = err; t.silent = silent;
    t.rdata = rdata;
    return t;
  endfunction

  // Issue one request and wait (bounded) for it to be accepted.
  task automatic do_req(input txn_t t, input bit expect_rsp);
    bit acc;
    slv_q.push_back(t);
    if (expect_rsp) exp_q.push_back(model_rsp(t));
    req_valid = 1'b1;
    req_we    = t.we;
    req_adr   = t.adr;
    req_dat   = t.wdat;
    req_sel   = t.sel;
    acc = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = req_ready_o;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      checks++;
      fail("req_accept", "req_ready_o never 1, required 1 within 300 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (req_ready_o) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      checks++;
      fail("wait_idle", "req_ready_o stuck 0, required 1 within 300 cycles");
    end
  endtask

  task automatic count_cyc(input int max, output int n);
    n = 0;
    while (wb_cyc_o && n < max) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Response back-pressure generator.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_hold) rsp_ready = 1'b0;
      else if (bp_random) rsp_ready = ($urandom_range(0, 2) != 0);
      else rsp_ready = 1'b1;
    end
  end

  // Wishbone target: replays the scripted behaviour of each transaction and
  // checks the bus fields; optionally drives stray ack/err while idle.
  initial begin
    txn_t cur;
    int   wait_cnt;
    bit   busy;
    bit   done;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat = '0;
    busy = 1'b0; done = 1'b0; wait_cnt = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    forever begin
      @(posedge clk); #1;
      wb_ack = 1'b0;
      wb_err = 1'b0;
      wb_dat = $urandom;
      if (!wb_cyc_o) begin
        busy = 1'b0;
        if (spur_en && $urandom_range(0, 7) == 0) begin
          wb_ack = $urandom_range(0, 1) == 1;
          wb_err = !wb_ack;
        end
      end else if (!busy) begin
        busy = 1'b1;
        done = 1'b0;
        checks++;
        if (slv_q.size() == 0) begin
          fail("bus_unexpected_cyc", "wb_cyc_o=1, required 0 (no request pending)");
          cur = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        end else begin
          cur = slv_q.pop_front();
          if (wb_stb_o !== 1'b1 || wb_we_o !== cur.we || wb_adr_o !== cur.adr ||
              wb_sel_o !== cur.sel || (cur.we && wb_dat_o !== cur.wdat))
            fail("bus_fields", $sformatf(
                 "stb=%0b we=%0b adr=%h dat=%h sel=%h, required stb=1 we=%0b adr=%h dat=%h sel=%h",
                 wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
                 cur.we, cur.adr, cur.wdat, cur.sel));
        end
        wait_cnt = cur.delay;
      end
      if (busy && !done && !cur.silent) begin
        if (wait_cnt == 0) begin
          wb_ack = cur.ack;
          wb_err = cur.err;
          wb_dat = cur.rdata;
          done   = 1'b1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: compares each response handshake against the scoreboard and
  // checks response stability and handshake rules every cycle.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_dat;
    logic        prev_err;
    rsp_t        e;
    prev_stall = 1'b0; prev_dat = '0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        checks++;
        if (wb_cyc_o !== wb_stb_o)
          fail("cyc_eq_stb", $sformatf("cyc=%0b stb=%0b, required equal", wb_cyc_o, wb_stb_o));
        if (prev_stall) begin
          checks++;
          if (rsp_valid_o !== 1'b1 || rsp_dat_o !== prev_dat || rsp_err_o !== prev_err)
            fail("rsp_stable", $sformatf("valid=%0b dat=%h err=%0b, required 1/%h/%0b",
                 rsp_valid_o, rsp_dat_o, rsp_err_o, prev_dat, prev_err));
        end
        if (rsp_valid_o) begin
          checks++;
          if (req_ready_o !== 1'b0 || wb_cyc_o !== 1'b0)
            fail("resp_quiet", $sformatf("req_ready=%0b cyc=%0b, required 0/0",
                 req_ready_o, wb_cyc_o));
        end
        if (rsp_valid_o && rsp_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            fail("rsp_unexpected", $sformatf("rsp_valid=1 dat=%h, required no response",
                 rsp_dat_o));
          end else begin
            e = exp_q.pop_front();
            if (rsp_dat_o !== e.dat || rsp_err_o !== e.err)
              fail("rsp_data", $sformatf("dat=%h err=%0b, required dat=%h err=%0b",
                   rsp_dat_o, rsp_err_o, e.dat, e.err));
          end
        end
        prev_stall = rsp_valid_o && !rsp_ready;
        prev_dat   = rsp_dat_o;
        prev_err   = rsp_err_o;
      end
    end
  end

  // Stimulus sequence.
  initial begin
    txn_t t;
    int   n;
    int   k;
    checks = 0; failures = 0;
    bp_hold = 1'b0; bp_random = 1'b0; spur_en = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_adr = '0; req_dat = '0; req_sel = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
         rsp_valid_o, rsp_dat_o, rsp_err_o} !== '0)
      fail("reset_outputs", $sformatf("cyc=%0b stb=%0b adr=%h rsp_valid=%0b, required all 0",
           wb_cyc_o, wb_stb_o, wb_adr_o, rsp_valid_o));
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1)
      fail("reset_ready", $sformatf("req_ready=%0b, required 1", req_ready_o));

    // Write to registered-ack target: two strobe cycles, then response
    do_req(mk(1, 32'h0, 32'h0000_A5A5, 4'hF, 1, 1, 0, 0, 32'h5555_AAAA), 1);
    count_cyc(50, n);
    checks++;
    if (n != 2) fail("write_stb_cycles", $sformatf("cyc high %0d cycles, required 2", n));
    checks++;
    if (rsp_valid_o !== 1'b1)
      fail("write_rsp_latency", $sformatf("rsp_valid=%0b after stb, required 1", rsp_valid_o));
    wait_idle();

    // Read with data return
    do_req(mk(0, 32'h4, 32'h0, 4'hF, 1, 1, 0, 0, 32'h1234_5678), 1);
    wait_idle();

    // ack and err together: err wins
    do_req(mk(0, 32'h8, 32'h0, 4'h3, 1, 1, 1, 0, 32'hDEAD_BEEF), 1);
    wait_idle();

    // Response held off for 10 cycles while another request waits
    bp_hold = 1'b1;
    @(posedge clk); #1;
    do_req(mk(0, 32'hC, 32'h0, 4'hF, 2, 1, 0, 0, 32'hCAFE_F00D), 1);
    for (int i = 0; i < 20 && !rsp_valid_o; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h40; req_dat = 32'h1; req_sel = 4'h1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'hCAFE_F00D || req_ready_o !== 1'b0 ||
          wb_cyc_o !== 1'b0)
        fail("hold_rsp", $sformatf("valid=%0b dat=%h ready=%0b cyc=%0b, required 1/cafef00d/0/0",
             rsp_valid_o, rsp_dat_o, req_ready_o, wb_cyc_o));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    bp_hold = 1'b0;
    wait_idle();

    // Randomised traffic with back-pressure and stray ack/err while idle
    bp_random = 1'b1;
    spur_en   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      t = mk($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), (k < 7) || (k >= 8), (k >= 7), 0, $urandom);
      do_req(t, 1);
    end
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    bp_random = 1'b0;
    spur_en   = 1'b0;
    wait_idle();
    checks++;
    if (exp_q.size() != 0)
      fail("drain_random", $sformatf("%0d responses outstanding, required 0", exp_q.size()));

    // Silent target
`ifdef WB_HM_TIMEOUT_EN
    do_req(mk(0, 32'h10, 32'h0, 4'hF, 0, 0, 0, 1, 32'h0), 1);
    count_cyc(1000, n);
    checks++;
    if (n != TIMEOUT) fail("timeout_cycles", $sformatf("cyc high %0d cycles, required %0d",
                            n, TIMEOUT));
    wait_idle();
    // Another silent cycle, interrupted by reset before timing out
    do_req(mk(0, 32'h14, 32'h0, 4'hF, 0, 0, 0, 1, 32'h0), 0);
    repeat (3) @(posedge clk);
    #1;
`else
    do_req(mk(0, 32'h10, 32'h0, 4'hF, 0, 0, 0, 1, 32'h0), 0);
    count_cyc(1000, n);
    checks++;
    if (n != 1000) fail("no_timeout_cycles", $sformatf("cyc high %0d cycles, required 1000", n));
`endif

    // Reset in the middle of a bus cycle
    checks++;
    if (wb_cyc_o !== 1'b1) fail("pre_reset_cyc", $sformatf("cyc=%0b, required 1", wb_cyc_o));
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid_o !== 1'b0)
      fail("async_reset", $sformatf("cyc=%0b stb=%0b rsp_valid=%0b, required 0/0/0",
           wb_cyc_o, wb_stb_o, rsp_valid_o));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1)
      fail("post_reset_ready", $sformatf("req_ready=%0b, required 1", req_ready_o));
    repeat (20) @(posedge clk);
    #1;

    // Recovery read after reset
    do_req(mk(0, 32'h20, 32'h0, 4'hF, 1, 1, 0, 0, 32'h0BAD_F00D), 1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    wait_idle();
    checks++;
    if (exp_q.size() != 0 || slv_q.size() != 0)
      fail("final_drain", $sformatf("rsp left=%0d bus left=%0d, required 0/0",
           exp_q.size(), slv_q.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
